mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers, parametrised in width.
//  It executes MULT/MULTU/DIV/DIVU over multiple cycles, and MTHI/MTLO in one cycle.
//  It sits in the execute stage beside the single-cycle ALU and receives rs/rt data from decode.
//  The hazard logic stalls the pipeline on md_o_busy.
// PARAMETERS
//  DWIDTH     32   operand width; HI and LO are each DWIDTH wide
//  CNT_WIDTH  $clog2(DWIDTH)+1  localparam; width of the iteration counter
// PORTS
//  md_clk      in   1       clock; all state changes on rising edge
//  md_rst      in   1       asynchronous, active-high reset
//  md_i_start  in   1       op request; sampled only when idle
//  md_i_op     in   3       000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op
//  md_i_rs     in   DWIDTH  multiplicand/dividend; source for MTHI/MTLO
//  md_i_rt     in   DWIDTH  multiplier/divisor
//  md_i_flush  in   1       pipeline flush; cancels an in-flight op
//  md_o_busy   out  1       multi-cycle op in progress
//  md_o_done   out  1       one-cycle pulse; HI/LO were just updated by a mult/div
//  md_o_hi     out  DWIDTH  HI register (registered output)
//  md_o_lo     out  DWIDTH  LO register (registered output)
// BEHAVIOUR
//  Reset (async, any time):
//   - state IDLE; hi = lo = 0; busy = 0; done = 0; counter and work registers cleared
//   - reset mid-op abandons the op
//  States: IDLE -> RUN -> FIX -> IDLE
//   - IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}, edge E0:
//     - latch operands: magnitudes for signed ops, raw values for unsigned
//     - latch sign info; counter = DWIDTH; busy = 1; go to RUN
//   - RUN, edges E1..E_DWIDTH, one bit per edge:
//     - mult: shift-add, 2*DWIDTH product
//     - div: restoring, 1 quotient bit per cycle
//     - counter decrements; at 0, go to FIX
//   - FIX, edge E_(DWIDTH+1):
//     - sign-correct the result and write HI/LO
//     - busy = 0; done = 1 for exactly one cycle; go to IDLE
//   - Latency: start edge to HI/LO valid = DWIDTH+1 edges; busy high for DWIDTH+1 cycles
//   - Next op may be accepted on the same edge that done is asserted (back-to-back)
//  MTHI/MTLO:
//   - IDLE, start=1: HI or LO <= rs at E0; no busy, no done
//  Arithmetic:
//   - mult: {HI,LO} = rs*rt, full 2*DWIDTH bits; signed product negated if operand signs differ
//   - div: LO = quotient, truncated toward zero; HI = remainder
//   - signed div: quotient negated if signs differ; remainder takes the dividend's sign
//   - divide by zero (both ops): LO = all ones, HI = rs; full latency; no exception
//   - signed MIN / -1: LO = MIN, HI = 0
//  Boundary rules:
//   - start (any op) while busy: ignored, not queued
//     - decode must stall any op while md_o_busy
//   - flush while busy: state IDLE and busy = 0 at the next edge; HI/LO unchanged; no done
//   - flush on the FIX edge: flush wins; HI/LO not written
//   - flush and start together while idle: start dropped
//   - invalid op codes: no effect
// TESTING (DWIDTH=32)
//  1 MULTU FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE, LO=00000001
//    - done one cycle, exactly 33 edges after start edge; busy high 33 cycles
//  2 MULT FFFFFFFD*00000007 -> HI=FFFFFFFF, LO=FFFFFFEB
//    then back-to-back DIVU 00000064/00000007 -> LO=0000000E, HI=00000002
//  3 DIV FFFFFFF9/00000002 -> LO=FFFFFFFD, HI=FFFFFFFF
//    DIV 80000000/FFFFFFFF -> LO=80000000, HI=00000000
//  4 DIVU 12345678/00000000 -> LO=FFFFFFFF, HI=12345678, done after full 33 edges
//  5 MTHI AAAA5555, MTLO 5555AAAA, then MULT 3*4 with flush at E10
//    - no done; busy low after E11; HI/LO keep AAAA5555/5555AAAA
//    - a start issued at E5 is ignored
//  6 assert md_rst asynchronously mid-DIV at E20
//    - hi, lo, busy, done all 0 before the next clock edge
//    - a fresh MULTU 2*3 after release gives HI=0, LO=6

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per
// cycle. Signed operations run on operand magnitudes and are sign-corrected
// in a final FIX cycle. MTHI/MTLO write HI or LO in a single cycle.
module mips_muldiv_unit #(
  parameter int DWIDTH = 32
) (
  input  logic              md_clk,
  input  logic              md_rst,
  input  logic              md_i_start,
  input  logic [2:0]        md_i_op,
  input  logic [DWIDTH-1:0] md_i_rs,
  input  logic [DWIDTH-1:0] md_i_rt,
  input  logic              md_i_flush,
  output logic              md_o_busy,
  output logic              md_o_done,
  output logic [DWIDTH-1:0] md_o_hi,
  output logic [DWIDTH-1:0] md_o_lo
);

  localparam int CNT_WIDTH = $clog2(DWIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [DWIDTH-1:0]    C_ZERO     = {DWIDTH{1'b0}};
  localparam logic [DWIDTH-1:0]    C_ONE      = {{(DWIDTH-1){1'b0}}, 1'b1};
  localparam logic [DWIDTH-1:0]    C_ONES     = {DWIDTH{1'b1}};
  localparam logic [2*DWIDTH-1:0]  C_ONE_2W   = {{(2*DWIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] C_CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] C_CNT_FULL = CNT_WIDTH'(DWIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Architectural and control state
  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [DWIDTH-1:0]     r_hi;
  logic [DWIDTH-1:0]     r_lo;
  // Work registers: r_whi/r_wlo hold partial product or remainder/quotient
  logic [DWIDTH-1:0]     r_whi;
  logic [DWIDTH-1:0]     r_wlo;
  logic [DWIDTH-1:0]     r_opb;      // multiplicand or divisor magnitude
  logic [DWIDTH-1:0]     r_rs_raw;   // raw dividend, returned in HI on divide by zero
  logic                  r_is_div;
  logic                  r_neg_q;    // product/quotient must be negated
  logic                  r_neg_r;    // remainder must be negated (dividend sign)
  logic                  r_dz;       // divisor was zero

  // Next-state values
  state_t                w_state;
  logic [CNT_WIDTH-1:0]  w_cnt;
  logic                  w_busy;
  logic                  w_done;
  logic [DWIDTH-1:0]     w_hi;
  logic [DWIDTH-1:0]     w_lo;
  logic [DWIDTH-1:0]     w_whi;
  logic [DWIDTH-1:0]     w_wlo;
  logic [DWIDTH-1:0]     w_opb;
  logic [DWIDTH-1:0]     w_rs_raw;
  logic                  w_is_div;
  logic                  w_neg_q;
  logic                  w_neg_r;
  logic                  w_dz;

  // Datapath helpers
  logic                  w_signed_op;
  logic [DWIDTH-1:0]     w_rs_mag;
  logic [DWIDTH-1:0]     w_rt_mag;
  logic [DWIDTH:0]       w_add;
  logic [DWIDTH:0]       w_shift;
  logic [DWIDTH:0]       w_diff;
  logic [2*DWIDTH-1:0]   w_prod;
  logic [2*DWIDTH-1:0]   w_prod_neg;
  logic [DWIDTH-1:0]     w_q_neg;
  logic [DWIDTH-1:0]     w_r_neg;

  // Operand conditioning and per-iteration arithmetic
  always_comb begin
    w_signed_op = (md_i_op == OP_MULT) || (md_i_op == OP_DIV);
    w_rs_mag    = (w_signed_op && md_i_rs[DWIDTH-1]) ? (~md_i_rs + C_ONE) : md_i_rs;
    w_rt_mag    = (w_signed_op && md_i_rt[DWIDTH-1]) ? (~md_i_rt + C_ONE) : md_i_rt;
    // Shift-add step: add multiplicand when the current multiplier bit is set
    w_add       = {1'b0, r_whi} + (r_wlo[0] ? {1'b0, r_opb} : {(DWIDTH+1){1'b0}});
    // Restoring-division step: shift in next dividend bit and trial-subtract
    w_shift     = {r_whi, r_wlo[DWIDTH-1]};
    w_diff      = w_shift - {1'b0, r_opb};
    w_prod      = {r_whi, r_wlo};
    w_prod_neg  = ~w_prod + C_ONE_2W;
    w_q_neg     = ~r_wlo + C_ONE;
    w_r_neg     = ~r_whi + C_ONE;
  end

  // Next-state and output logic for the IDLE -> RUN -> FIX sequence
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_hi     = r_hi;
    w_lo     = r_lo;
    w_whi    = r_whi;
    w_wlo    = r_wlo;
    w_opb    = r_opb;
    w_rs_raw = r_rs_raw;
    w_is_div = r_is_div;
    w_neg_q  = r_neg_q;
    w_neg_r  = r_neg_r;
    w_dz     = r_dz;
    case (r_state)
      ST_IDLE: begin
        if (md_i_start && !md_i_flush) begin
          case (md_i_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              w_state  = ST_RUN;
              w_cnt    = C_CNT_FULL;
              w_busy   = 1'b1;
              w_whi    = C_ZERO;
              w_wlo    = w_rs_mag;
              w_opb    = w_rt_mag;
              w_rs_raw = md_i_rs;
              w_is_div = md_i_op[1];
              w_neg_q  = w_signed_op && (md_i_rs[DWIDTH-1] ^ md_i_rt[DWIDTH-1]);
              w_neg_r  = w_signed_op && md_i_rs[DWIDTH-1];
              w_dz     = (md_i_rt == C_ZERO);
            end
            OP_MTHI: begin
              w_hi = md_i_rs;
            end
            OP_MTLO: begin
              w_lo = md_i_rs;
            end
            default: begin
              w_state = ST_IDLE;
            end
          endcase
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (md_i_flush) begin
          w_state = ST_IDLE;
          w_busy  = 1'b0;
          w_cnt   = C_CNT_ZERO;
        end else begin
          if (r_is_div) begin
            w_wlo = {r_wlo[DWIDTH-2:0], ~w_diff[DWIDTH]};
            w_whi = w_diff[DWIDTH] ? w_shift[DWIDTH-1:0] : w_diff[DWIDTH-1:0];
          end else begin
            w_whi = w_add[DWIDTH:1];
            w_wlo = {w_add[0], r_wlo[DWIDTH-1:1]};
          end
          w_cnt = r_cnt - C_CNT_ONE;
          if (r_cnt == C_CNT_ONE) begin
            w_state = ST_FIX;
          end else begin
            w_state = ST_RUN;
          end
        end
      end
      ST_FIX: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
        if (md_i_flush) begin
          w_done = 1'b0;
        end else begin
          w_done = 1'b1;
          if (!r_is_div) begin
            {w_hi, w_lo} = r_neg_q ? w_prod_neg : w_prod;
          end else if (r_dz) begin
            w_lo = C_ONES;
            w_hi = r_rs_raw;
          end else begin
            w_lo = r_neg_q ? w_q_neg : r_wlo;
            w_hi = r_neg_r ? w_r_neg : r_whi;
          end
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State register with asynchronous reset abandoning any op in flight
  always_ff @(posedge md_clk or posedge md_rst) begin
    if (md_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= C_CNT_ZERO;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= C_ZERO;
      r_lo     <= C_ZERO;
      r_whi    <= C_ZERO;
      r_wlo    <= C_ZERO;
      r_opb    <= C_ZERO;
      r_rs_raw <= C_ZERO;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_hi     <= w_hi;
      r_lo     <= w_lo;
      r_whi    <= w_whi;
      r_wlo    <= w_wlo;
      r_opb    <= w_opb;
      r_rs_raw <= w_rs_raw;
      r_is_div <= w_is_div;
      r_neg_q  <= w_neg_q;
      r_neg_r  <= w_neg_r;
      r_dz     <= w_dz;
    end
  end

  assign md_o_busy = r_busy;
  assign md_o_done = r_done;
  assign md_o_hi   = r_hi;
  assign md_o_lo   = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed testbench for mips_muldiv_unit (DWIDTH = 32).
module tb_mips_muldiv_unit;

  logic        clk_s;
  logic        rst_s;
  logic        start_s;
  logic [2:0]  op_s;
  logic [31:0] rs_s;
  logic [31:0] rt_s;
  logic        flush_s;
  logic        busy_s;
  logic        done_s;
  logic [31:0] hi_s;
  logic [31:0] lo_s;

  int checks_s;
  int errors_s;
  int edges_s;
  int bcyc_s;
  int done_seen_s;

  mips_muldiv_unit #(.DWIDTH(32)) dut (
    .md_clk     (clk_s),
    .md_rst     (rst_s),
    .md_i_start (start_s),
    .md_i_op    (op_s),
    .md_i_rs    (rs_s),
    .md_i_rt    (rt_s),
    .md_i_flush (flush_s),
    .md_o_busy  (busy_s),
    .md_o_done  (done_s),
    .md_o_hi    (hi_s),
    .md_o_lo    (lo_s)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk_s = 1'b0;
    forever #5 clk_s = ~clk_s;
  end

  // Watchdog in case the sequence stalls
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_s++;
    assert (obs === exp) else begin
      errors_s++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  // Issue one op at the next edge (E0), then wait for done with a bound
  task automatic do_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int edges, output int bcyc);
    start_s = 1'b1;
    op_s    = op;
    rs_s    = rs;
    rt_s    = rt;
    tick();
    start_s = 1'b0;
    edges   = 0;
    bcyc    = 0;
    while (done_s !== 1'b1 && edges < 100) begin
      if (busy_s === 1'b1) bcyc++;
      tick();
      edges++;
    end
  endtask

  initial begin
    checks_s = 0;
    errors_s = 0;
    rst_s    = 1'b1;
    start_s  = 1'b0;
    op_s     = 3'b000;
    rs_s     = 32'h0;
    rt_s     = 32'h0;
    flush_s  = 1'b0;

    // Reset state
    tick();
    chk("reset_hi", {32'h0, hi_s}, 64'h0);
    chk("reset_lo", {32'h0, lo_s}, 64'h0);
    chk("reset_busy_done", {62'h0, busy_s, done_s}, 64'h0);
    rst_s = 1'b0;
    tick();

    // 1: MULTU all ones, latency and busy length
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges_s, bcyc_s);
    chk("t1_edges", 64'(edges_s), 64'd33);
    chk("t1_busy_cycles", 64'(bcyc_s), 64'd33);
    chk("t1_hilo", {hi_s, lo_s}, 64'hFFFF_FFFE_0000_0001);
    chk("t1_busy_at_done", {63'h0, busy_s}, 64'h0);
    tick();
    chk("t1_done_one_cycle", {63'h0, done_s}, 64'h0);

    // 2: MULT negative * positive, then back-to-back DIVU
    do_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, edges_s, bcyc_s);
    chk("t2_mult_hilo", {hi_s, lo_s}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("t2_done_seen", {63'h0, done_s}, 64'h1);
    do_op(3'b011, 32'h0000_0064, 32'h0000_0007, edges_s, bcyc_s);
    chk("t2_divu_edges", 64'(edges_s), 64'd33);
    chk("t2_divu_hilo", {hi_s, lo_s}, 64'h0000_0002_0000_000E);

    // 3: signed divides, including MIN / -1
    do_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, edges_s, bcyc_s);
    chk("t3_div_neg_hilo", {hi_s, lo_s}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, edges_s, bcyc_s);
    chk("t3_div_min_hilo", {hi_s, lo_s}, 64'h0000_0000_8000_0000);

    // 4: DIVU by zero
    do_op(3'b011, 32'h1234_5678, 32'h0000_0000, edges_s, bcyc_s);
    chk("t4_dz_edges", 64'(edges_s), 64'd33);
    chk("t4_dz_hilo", {hi_s, lo_s}, 64'h1234_5678_FFFF_FFFF);

    // 5: MTHI / MTLO single cycle, no busy, no done
    start_s = 1'b1; op_s = 3'b100; rs_s = 32'hAAAA_5555;
    tick();
    start_s = 1'b0;
    chk("t5_mthi", {32'h0, hi_s}, {32'h0, 32'hAAAA_5555});
    chk("t5_mthi_busy_done", {62'h0, busy_s, done_s}, 64'h0);
    start_s = 1'b1; op_s = 3'b101; rs_s = 32'h5555_AAAA;
    tick();
    start_s = 1'b0;
    chk("t5_mtlo", {32'h0, lo_s}, {32'h0, 32'h5555_AAAA});
    // Invalid op code and start-with-flush while idle have no effect
    start_s = 1'b1; op_s = 3'b110; rs_s = 32'h1111_1111;
    tick();
    chk("t5_invalid_busy", {63'h0, busy_s}, 64'h0);
    op_s = 3'b100; flush_s = 1'b1;
    tick();
    start_s = 1'b0; flush_s = 1'b0;
    chk("t5_idle_flush_start", {hi_s, lo_s}, 64'hAAAA_5555_5555_AAAA);
    // MULT 3*4, start ignored at E5, flush sampled at E11
    start_s = 1'b1; op_s = 3'b000; rs_s = 32'd3; rt_s = 32'd4;
    tick();
    start_s = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    start_s = 1'b1; op_s = 3'b001; rs_s = 32'd5; rt_s = 32'd5;
    tick();
    start_s = 1'b0;
    chk("t5_busy_after_e5", {63'h0, busy_s}, 64'h1);
    for (int i = 6; i <= 10; i++) tick();
    chk("t5_busy_at_e10", {63'h0, busy_s}, 64'h1);
    flush_s = 1'b1;
    tick();
    flush_s = 1'b0;
    chk("t5_busy_after_flush", {63'h0, busy_s}, 64'h0);
    done_seen_s = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_s === 1'b1) done_seen_s++;
      tick();
    end
    chk("t5_no_done", 64'(done_seen_s), 64'd0);
    chk("t5_hilo_kept", {hi_s, lo_s}, 64'hAAAA_5555_5555_AAAA);

    // 6: asynchronous reset mid-DIV at E20
    start_s = 1'b1; op_s = 3'b010; rs_s = 32'd100; rt_s = 32'd7;
    tick();
    start_s = 1'b0;
    for (int i = 1; i <= 20; i++) tick();
    #2;
    rst_s = 1'b1;
    #1;
    chk("t6_async_hilo", {hi_s, lo_s}, 64'h0);
    chk("t6_async_busy_done", {62'h0, busy_s, done_s}, 64'h0);
    tick();
    rst_s = 1'b0;
    tick();
    do_op(3'b001, 32'd2, 32'd3, edges_s, bcyc_s);
    chk("t6_mult_after_reset", {hi_s, lo_s}, 64'h0000_0000_0000_0006);

    // Flush on the FIX edge: no done, HI/LO not written
    start_s = 1'b1; op_s = 3'b001; rs_s = 32'd7; rt_s = 32'd9;
    tick();
    start_s = 1'b0;
    for (int i = 1; i <= 32; i++) tick();
    flush_s = 1'b1;
    tick();
    flush_s = 1'b0;
    chk("fix_flush_busy_done", {62'h0, busy_s, done_s}, 64'h0);
    chk("fix_flush_hilo", {hi_s, lo_s}, 64'h0000_0000_0000_0006);

    $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
    $finish;
  end

endmodule
